// File: rtl/ysyx_22050598_muldiv_unit.sv
// ysyx_22050598_muldiv_unit: iterative RV64M multiply/divide, one result bit per cycle.
// Define YSYX_22050598_MULDIV_WFAST_EN to run word ops on a 32-iteration datapath.
module ysyx_22050598_muldiv_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            muldiv_valid,
    input  logic [3:0]      muldiv_op,
    input  logic [XLEN-1:0] muldiv_src1,
    input  logic [XLEN-1:0] muldiv_src2,
    input  logic            muldiv_flush,
    output logic            muldiv_ready,
    output logic            muldivout_valid,
    output logic [XLEN-1:0] muldiv_result
);
`ifdef YSYX_22050598_MULDIV_WFAST_EN
    localparam bit WFAST = 1'b1;
`else
    localparam bit WFAST = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
    state_e       state_q;
    logic [6:0]   cnt_q;
    logic [3:0]   op_q;
    logic [63:0]  m_q, res_q;
    logic [127:0] p_q;
    logic         neg_q, rneg_q;
    logic [3:0]   op_n;
    logic         mul_n, word_n, rem_n, sgn1_n, sgn2_n, neg1_n, neg2_n, fast_n, dbz_n;
    logic [63:0]  x1_n, x2_n, ab1_n, ab2_n, lo_n, dbz_res_n;
    logic [127:0] p_init_n;
    assign op_n      = (muldiv_op > 4'd12) ? 4'd0 : muldiv_op;
    assign mul_n     = (op_n < 4'd4) || (op_n == 4'd8);
    assign word_n    = op_n >= 4'd8;
    assign rem_n     = op_n inside {4'd6, 4'd7, 4'd11, 4'd12};
    assign sgn1_n    = op_n inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd6, 4'd9, 4'd11};
    assign sgn2_n    = op_n inside {4'd0, 4'd1, 4'd4, 4'd6, 4'd9, 4'd11};
    assign x1_n      = word_n ? {{32{sgn1_n & muldiv_src1[31]}}, muldiv_src1[31:0]} : muldiv_src1;
    assign x2_n      = word_n ? {{32{sgn2_n & muldiv_src2[31]}}, muldiv_src2[31:0]} : muldiv_src2;
    assign neg1_n    = sgn1_n & x1_n[63];
    assign neg2_n    = sgn2_n & x2_n[63];
    assign ab1_n     = neg1_n ? -x1_n : x1_n;
    assign ab2_n     = neg2_n ? -x2_n : x2_n;
    assign fast_n    = WFAST & word_n;
    assign dbz_n     = ~mul_n & (x2_n == 64'd0);
    assign lo_n      = mul_n ? ab2_n : ab1_n;
    // Multiply consumes the low end of p, divide shifts the dividend out of the top
    assign p_init_n  = !fast_n ? {64'd0, lo_n} : mul_n ? {96'd0, lo_n[31:0]} : {64'd0, lo_n[31:0], 32'd0};
    assign dbz_res_n = !rem_n ? '1 : word_n ? {{32{x1_n[31]}}, x1_n[31:0]} : x1_n;
    logic         mul_q, word_q, rem_q, fast_q, ge;
    logic [64:0]  sum, rsh;
    logic [127:0] p_nx, prod, sprod;
    logic [63:0]  quot, q, r, raw, fix;
    assign mul_q  = (op_q < 4'd4) || (op_q == 4'd8);
    assign word_q = op_q >= 4'd8;
    assign rem_q  = op_q inside {4'd6, 4'd7, 4'd11, 4'd12};
    assign fast_q = WFAST & word_q;
    assign sum    = {1'b0, p_q[127:64]} + (p_q[0] ? {1'b0, m_q} : 65'd0);
    assign rsh    = p_q[127:63];
    assign ge     = rsh >= {1'b0, m_q};
    assign p_nx   = mul_q ? {sum, p_q[63:1]} : {ge ? rsh[63:0] - m_q : rsh[63:0], p_q[62:0], ge};
    assign prod   = fast_q ? p_nx >> 32 : p_nx;
    assign sprod  = neg_q ? -prod : prod;
    assign quot   = fast_q ? {32'd0, p_nx[31:0]} : p_nx[63:0];
    assign q      = neg_q ? -quot : quot;
    assign r      = rneg_q ? -p_nx[127:64] : p_nx[127:64];
    assign raw    = mul_q ? ((op_q inside {4'd1, 4'd2, 4'd3}) ? sprod[127:64] : sprod[63:0]) : rem_q ? r : q;
    assign fix    = word_q ? {{32{raw[31]}}, raw[31:0]} : raw;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            m_q     <= '0;
            p_q     <= '0;
            res_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (muldiv_valid && !muldiv_flush) begin
                    op_q    <= op_n;
                    m_q     <= mul_n ? ab1_n : ab2_n;
                    p_q     <= p_init_n;
                    neg_q   <= neg1_n ^ neg2_n;
                    rneg_q  <= neg1_n;
                    cnt_q   <= fast_n ? 7'd32 : 7'd64;
                    if (dbz_n) res_q <= dbz_res_n;
                    state_q <= dbz_n ? DONE : CALC;
                end
                CALC: if (muldiv_flush) state_q <= IDLE;
                else begin
                    p_q   <= p_nx;
                    cnt_q <= cnt_q - 7'd1;
                    if (cnt_q == 7'd1) begin
                        res_q   <= fix;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign muldiv_ready    = state_q == IDLE;
    assign muldivout_valid = (state_q == DONE) && !muldiv_flush;
    assign muldiv_result   = res_q;
endmodule

// File: tb/tb_ysyx_22050598_muldiv_unit.sv
// tb_ysyx_22050598_muldiv_unit: random and directed checks of the muldiv unit against an arithmetic model.
module tb_ysyx_22050598_muldiv_unit;
`ifdef YSYX_22050598_MULDIV_WFAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    logic        clk = 1'b0, rst_n = 1'b0, muldiv_valid = 1'b0, muldiv_flush = 1'b0;
    logic [3:0]  muldiv_op = '0;
    logic [63:0] muldiv_src1 = '0, muldiv_src2 = '0;
    logic        muldiv_ready, muldivout_valid;
    logic [63:0] muldiv_result;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    ysyx_22050598_muldiv_unit dut (
        .clk(clk), .rst_n(rst_n), .muldiv_valid(muldiv_valid), .muldiv_op(muldiv_op),
        .muldiv_src1(muldiv_src1), .muldiv_src2(muldiv_src2), .muldiv_flush(muldiv_flush),
        .muldiv_ready(muldiv_ready), .muldivout_valid(muldivout_valid), .muldiv_result(muldiv_result)
    );
    typedef struct {logic [3:0] op; logic [63:0] a, b, exp;} vec_t;
    function automatic logic [3:0] norm(input logic [3:0] op);
        return (op > 4'd12) ? 4'd0 : op;
    endfunction
    function automatic logic [63:0] sx32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction
    function automatic bit is_dbz(input logic [3:0] op, input logic [63:0] b);
        logic [3:0] o = norm(op);
        if (o inside {4'd4, 4'd5, 4'd6, 4'd7}) return b == 64'd0;
        if (o inside {4'd9, 4'd10, 4'd11, 4'd12}) return b[31:0] == 32'd0;
        return 1'b0;
    endfunction
    function automatic int exp_lat(input logic [3:0] op, input logic [63:0] b);
        if (is_dbz(op, b)) return 1;
        return (FAST && norm(op) >= 4'd8) ? 33 : 65;
    endfunction
    function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sa, sb, ua, ub, wa, wb, wua, wub, r;
        sa = {{64{a[63]}}, a}; sb = {{64{b[63]}}, b};
        ua = {64'd0, a};       ub = {64'd0, b};
        wa = {{96{a[31]}}, a[31:0]}; wb = {{96{b[31]}}, b[31:0]};
        wua = {96'd0, a[31:0]};      wub = {96'd0, b[31:0]};
        case (norm(op))
            4'd1: begin r = sa * sb; return r[127:64]; end
            4'd2: begin r = sa * ub; return r[127:64]; end
            4'd3: begin r = ua * ub; return r[127:64]; end
            4'd4: begin if (b == 0) return '1; r = sa / sb; return r[63:0]; end
            4'd5: begin if (b == 0) return '1; r = ua / ub; return r[63:0]; end
            4'd6: begin if (b == 0) return a; r = sa % sb; return r[63:0]; end
            4'd7: begin if (b == 0) return a; r = ua % ub; return r[63:0]; end
            4'd8: begin r = wa * wb; return sx32(r[31:0]); end
            4'd9: begin if (b[31:0] == 0) return '1; r = wa / wb; return sx32(r[31:0]); end
            4'd10: begin if (b[31:0] == 0) return '1; r = wua / wub; return sx32(r[31:0]); end
            4'd11: begin if (b[31:0] == 0) return sx32(a[31:0]); r = wa % wb; return sx32(r[31:0]); end
            4'd12: begin if (b[31:0] == 0) return sx32(a[31:0]); r = wua % wub; return sx32(r[31:0]); end
            default: begin r = sa * sb; return r[63:0]; end
        endcase
    endfunction
    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'($urandom_range(0, 20));
            4: return {$urandom, 32'd0};
            5: return sx32(32'h8000_0000);
            default: return {$urandom, $urandom};
        endcase
    endfunction
    task automatic do_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] res, output int lat);
        @(negedge clk);
        muldiv_op = op; muldiv_src1 = a; muldiv_src2 = b; muldiv_valid = 1'b1;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!muldivout_valid && lat < 200);
        res = muldiv_result;
        muldiv_valid = 1'b0;
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (muldiv_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", muldiv_ready); end
        checks++; if (muldivout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", muldivout_valid); end
        checks++; if (muldiv_result !== 64'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", muldiv_result); end
        rst_n = 1'b1;
    endtask
    task automatic test_directed();
        vec_t v[$];
        logic [63:0] res;
        int lat;
        v.push_back('{4'd0,  64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB});
        v.push_back('{4'd3,  '1, '1, 64'hFFFF_FFFF_FFFF_FFFE});
        v.push_back('{4'd1,  '1, '1, 64'd0});
        v.push_back('{4'd4,  64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000});
        v.push_back('{4'd6,  64'h8000_0000_0000_0000, '1, 64'd0});
        v.push_back('{4'd5,  64'd5, 64'd0, '1});
        v.push_back('{4'd7,  64'd5, 64'd0, 64'd5});
        v.push_back('{4'd9,  64'hFFFF_FFFF_8000_0000, '1, 64'hFFFF_FFFF_8000_0000});
        v.push_back('{4'd11, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1});
        v.push_back('{4'd9,  64'd123, 64'h5_0000_0000, '1});
        v.push_back('{4'd11, 64'h1_8000_0000, 64'h1_0000_0000, 64'hFFFF_FFFF_8000_0000});
        v.push_back('{4'd8,  64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE});
        v.push_back('{4'd14, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB});
        foreach (v[i]) begin
            do_op(v[i].op, v[i].a, v[i].b, res, lat);
            checks++; if (res !== v[i].exp) begin errors++; $display("FAIL dir%0d_op%0d_result: got %h expected %h", i, v[i].op, res, v[i].exp); end
            checks++; if (lat != exp_lat(v[i].op, v[i].b)) begin errors++; $display("FAIL dir%0d_op%0d_latency: got %0d expected %0d", i, v[i].op, lat, exp_lat(v[i].op, v[i].b)); end
        end
    endtask
    task automatic test_random();
        logic [63:0] a, b, res, exp;
        logic [3:0] op;
        int lat;
        for (int i = 0; i < 48; i++) begin
            op = 4'($urandom_range(0, 15)); a = pick(); b = pick();
            exp = model(op, a, b);
            do_op(op, a, b, res, lat);
            checks++; if (res !== exp) begin errors++; $display("FAIL rand%0d_op%0d_result: a=%h b=%h got %h expected %h", i, op, a, b, res, exp); end
            checks++; if (lat != exp_lat(op, b)) begin errors++; $display("FAIL rand%0d_op%0d_latency: got %0d expected %0d", i, op, lat, exp_lat(op, b)); end
        end
    endtask
    task automatic test_back_to_back();
        logic [63:0] a1, b1, a2, b2;
        int n;
        a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom} | 64'd1;
        a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom} | 64'd1;
        @(negedge clk);
        muldiv_op = 4'd4; muldiv_src1 = a1; muldiv_src2 = b1; muldiv_valid = 1'b1;
        @(negedge clk);
        checks++; if (muldiv_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_drop: got %b expected 0", muldiv_ready); end
        n = 1;
        while (!muldivout_valid && n < 200) begin @(negedge clk); n++; end
        checks++; if (n != 65) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 65", n); end
        checks++; if (muldiv_result !== model(4'd4, a1, b1)) begin errors++; $display("FAIL b2b_first_result: got %h expected %h", muldiv_result, model(4'd4, a1, b1)); end
        checks++; if (muldiv_ready !== 1'b0) begin errors++; $display("FAIL b2b_strobe_ready: got %b expected 0", muldiv_ready); end
        muldiv_op = 4'd11; muldiv_src1 = a2; muldiv_src2 = b2;
        @(negedge clk);
        checks++; if (muldiv_ready !== 1'b1 || muldivout_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got ready=%b valid=%b expected ready=1 valid=0", muldiv_ready, muldivout_valid); end
        n = 0;
        do begin @(negedge clk); n++; end while (!muldivout_valid && n < 200);
        muldiv_valid = 1'b0;
        checks++; if (n != exp_lat(4'd11, b2)) begin errors++; $display("FAIL b2b_second_latency: got %0d expected %0d", n, exp_lat(4'd11, b2)); end
        checks++; if (muldiv_result !== model(4'd11, a2, b2)) begin errors++; $display("FAIL b2b_second_result: got %h expected %h", muldiv_result, model(4'd11, a2, b2)); end
    endtask
    task automatic test_flush();
        logic [63:0] a, b;
        bit seen;
        int n;
        a = {$urandom, $urandom}; b = {$urandom, $urandom} | 64'd1;
        seen = 1'b0;
        @(negedge clk);
        muldiv_op = 4'd4; muldiv_src1 = a; muldiv_src2 = b; muldiv_valid = 1'b1;
        repeat (10) begin @(negedge clk); if (muldivout_valid) seen = 1'b1; end
        muldiv_flush = 1'b1;
        @(negedge clk);
        checks++; if (muldiv_ready !== 1'b1) begin errors++; $display("FAIL flush_calc_ready: got %b expected 1", muldiv_ready); end
        muldiv_flush = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        muldiv_op = 4'd0; muldiv_src1 = a; muldiv_src2 = b;
        n = 0;
        do begin @(negedge clk); n++; if (muldivout_valid && n < 65) seen = 1'b1; end while (!muldivout_valid && n < 200);
        muldiv_valid = 1'b0;
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_strobe: got strobe=%b expected 0", seen); end
        checks++; if (n != 65) begin errors++; $display("FAIL flush_next_latency: got %0d expected 65", n); end
        checks++; if (muldiv_result !== model(4'd0, a, b)) begin errors++; $display("FAIL flush_next_result: got %h expected %h", muldiv_result, model(4'd0, a, b)); end
        @(negedge clk);
        muldiv_op = 4'd5; muldiv_src1 = 64'd5; muldiv_src2 = 64'd0; muldiv_valid = 1'b1;
        @(negedge clk);
        checks++; if (muldivout_valid !== 1'b1) begin errors++; $display("FAIL dbz_strobe_t1: got %b expected 1", muldivout_valid); end
        muldiv_flush = 1'b1;
        #1;
        checks++; if (muldivout_valid !== 1'b0) begin errors++; $display("FAIL flush_done_valid: got %b expected 0", muldivout_valid); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (muldiv_ready !== 1'b1) begin errors++; $display("FAIL flush_idle_block%0d: got ready=%b expected 1", i, muldiv_ready); end
        end
        muldiv_flush = 1'b0; muldiv_valid = 1'b0;
    endtask
    task automatic test_async_reset();
        logic [63:0] res, a, b;
        int lat;
        do_op(4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, res, lat);
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL arst_pre_result: got %h expected fffffffffffffFEB", res); end
        @(negedge clk);
        muldiv_op = 4'd1; muldiv_src1 = {$urandom, $urandom}; muldiv_src2 = {$urandom, $urandom}; muldiv_valid = 1'b1;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (muldiv_ready !== 1'b1) begin errors++; $display("FAIL arst_ready: got %b expected 1", muldiv_ready); end
        checks++; if (muldivout_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b expected 0", muldivout_valid); end
        checks++; if (muldiv_result !== 64'd0) begin errors++; $display("FAIL arst_result: got %h expected 0", muldiv_result); end
        muldiv_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        do_op(4'd2, a, b, res, lat);
        checks++; if (res !== model(4'd2, a, b)) begin errors++; $display("FAIL arst_post_result: got %h expected %h", res, model(4'd2, a, b)); end
        checks++; if (lat != 65) begin errors++; $display("FAIL arst_post_latency: got %0d expected 65", lat); end
    endtask
    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
